// File: rtl/bsg_print_stat_issuer_pkg.sv
// Shared definitions for the tile-side print-stat packet issuer.
package bsg_print_stat_issuer_pkg;

  localparam logic [27:0] bsg_print_stat_epa_gp = 28'h000_0D0C;

  typedef enum logic [1:0] {
    eIdle   = 2'b00,
    eSend   = 2'b01,
    eFenced = 2'b10
  } bsg_print_stat_issuer_state_e;

  // Store byte-mask width for a given data width
  function automatic int unsigned bsg_print_stat_mask_width(input int unsigned data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small circular-buffer FIFO; ready depends only on the registered full flag.
module bsg_fifo_1r1w_small #(
  parameter int unsigned width_p = 32,
  parameter int unsigned els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int unsigned ptr_width_lp   = $clog2(els_p);
  localparam int unsigned count_width_lp = $clog2(els_p + 1);

  logic [width_p-1:0]        mem_r [els_p];
  logic [ptr_width_lp-1:0]   wptr_r, rptr_r;
  logic [count_width_lp-1:0] count_r, count_n_s;
  logic                      full_r;
  logic                      enq_s, deq_s;

  // Pointer advance with wrap for non-power-of-two depths
  function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
    if (p == ptr_width_lp'(els_p - 1)) begin
      return {ptr_width_lp{1'b0}};
    end else begin
      return p + ptr_width_lp'(1);
    end
  endfunction

  assign enq_s   = v_i & ~full_r;
  assign deq_s   = yumi_i & v_o;
  assign ready_o = ~full_r;
  assign v_o     = (count_r != {count_width_lp{1'b0}});
  assign data_o  = mem_r[rptr_r];

  // Occupancy after this cycle's enqueue/dequeue
  always_comb begin
    count_n_s = count_r;
    if (enq_s & ~deq_s) begin
      count_n_s = count_r + count_width_lp'(1);
    end else if (deq_s & ~enq_s) begin
      count_n_s = count_r - count_width_lp'(1);
    end else begin
      count_n_s = count_r;
    end
  end

  // Pointer, occupancy and full-flag registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_r  <= {ptr_width_lp{1'b0}};
      rptr_r  <= {ptr_width_lp{1'b0}};
      count_r <= {count_width_lp{1'b0}};
      full_r  <= 1'b0;
    end else begin
      if (enq_s) wptr_r <= ptr_inc(wptr_r);
      if (deq_s) rptr_r <= ptr_inc(rptr_r);
      count_r <= count_n_s;
      full_r  <= (count_n_s == count_width_lp'(els_p));
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk_i) begin
    if (enq_s) mem_r[wptr_r] <= data_i;
  end

endmodule

// File: rtl/bsg_print_stat_issuer.sv
// Buffers stat tags and issues them as credit-limited remote stores to the
// host print-stat EPA, with a fence that drains outstanding credits.
module bsg_print_stat_issuer
  import bsg_print_stat_issuer_pkg::*;
#(
  parameter int unsigned x_cord_width_p    = 7,
  parameter int unsigned y_cord_width_p    = 7,
  parameter int unsigned addr_width_p      = 28,
  parameter int unsigned data_width_p      = 32,
  parameter logic [addr_width_p-1:0] print_stat_epa_p = addr_width_p'(bsg_print_stat_epa_gp),
  parameter int unsigned tag_fifo_els_p    = 4,
  parameter int unsigned max_out_credits_p = 8
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic                                   tag_v_i,
  input  logic [data_width_p-1:0]                tag_i,
  output logic                                   tag_ready_o,
  input  logic [x_cord_width_p-1:0]              my_x_i,
  input  logic [y_cord_width_p-1:0]              my_y_i,
  input  logic [x_cord_width_p-1:0]              dest_x_i,
  input  logic [y_cord_width_p-1:0]              dest_y_i,
  input  logic                                   fence_i,
  output logic                                   out_v_o,
  output logic [addr_width_p-1:0]                out_addr_o,
  output logic [data_width_p-1:0]                out_data_o,
  output logic [(data_width_p/8)-1:0]            out_mask_o,
  output logic [x_cord_width_p-1:0]              out_src_x_o,
  output logic [y_cord_width_p-1:0]              out_src_y_o,
  output logic [x_cord_width_p-1:0]              out_dest_x_o,
  output logic [y_cord_width_p-1:0]              out_dest_y_o,
  input  logic                                   out_ready_i,
  input  logic                                   credit_v_i,
  output logic [$clog2(max_out_credits_p+1)-1:0] credits_o,
  output logic                                   fence_done_o,
  output logic                                   error_o
);

  localparam int unsigned mask_width_lp   = bsg_print_stat_mask_width(data_width_p);
  localparam int unsigned credit_width_lp = $clog2(max_out_credits_p + 1);
  localparam logic [credit_width_lp-1:0] max_credits_lp = credit_width_lp'(max_out_credits_p);

  bsg_print_stat_issuer_state_e state_r;

  logic                       fifo_v_s, fifo_ready_s;
  logic [data_width_p-1:0]    fifo_data_s;
  logic                       load_s, hs_s, overflow_s;
  logic [credit_width_lp-1:0] credits_r, credits_n_s;

  logic                       out_v_r, fence_done_r, error_r;
  logic [addr_width_p-1:0]    out_addr_r;
  logic [data_width_p-1:0]    out_data_r;
  logic [mask_width_lp-1:0]   out_mask_r;
  logic [x_cord_width_p-1:0]  out_src_x_r, out_dest_x_r;
  logic [y_cord_width_p-1:0]  out_src_y_r, out_dest_y_r;

  bsg_fifo_1r1w_small #(
    .width_p(data_width_p),
    .els_p  (tag_fifo_els_p)
  ) tag_fifo (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .v_i    (tag_v_i),
    .data_i (tag_i),
    .ready_o(fifo_ready_s),
    .v_o    (fifo_v_s),
    .data_o (fifo_data_s),
    .yumi_i (load_s)
  );

  // Issue decision and credit arithmetic for the current cycle
  always_comb begin
    hs_s        = out_v_r & out_ready_i;
    load_s      = 1'b0;
    overflow_s  = 1'b0;
    credits_n_s = credits_r;
    case (state_r)
      eIdle:   load_s = fifo_v_s & ~fence_i & (credits_r != {credit_width_lp{1'b0}});
      // Back-to-back reload must leave a credit for itself after this handshake
      eSend:   load_s = hs_s & fifo_v_s & ~fence_i & (credits_r > credit_width_lp'(1));
      eFenced: load_s = 1'b0;
      default: load_s = 1'b0;
    endcase
    if (hs_s & ~credit_v_i) begin
      credits_n_s = credits_r - credit_width_lp'(1);
    end else if (~hs_s & credit_v_i) begin
      if (credits_r == max_credits_lp) begin
        overflow_s = 1'b1;
      end else begin
        credits_n_s = credits_r + credit_width_lp'(1);
      end
    end else begin
      credits_n_s = credits_r;
    end
  end

  // Issuer FSM, output packet register, credit counter and status flags
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r      <= eIdle;
      out_v_r      <= 1'b0;
      out_addr_r   <= {addr_width_p{1'b0}};
      out_data_r   <= {data_width_p{1'b0}};
      out_mask_r   <= {mask_width_lp{1'b0}};
      out_src_x_r  <= {x_cord_width_p{1'b0}};
      out_src_y_r  <= {y_cord_width_p{1'b0}};
      out_dest_x_r <= {x_cord_width_p{1'b0}};
      out_dest_y_r <= {y_cord_width_p{1'b0}};
      credits_r    <= max_credits_lp;
      fence_done_r <= 1'b0;
      error_r      <= 1'b0;
    end else begin
      credits_r    <= credits_n_s;
      error_r      <= error_r | overflow_s;
      fence_done_r <= (state_r == eFenced) & fence_i & ~fifo_v_s & (credits_r == max_credits_lp);
      if (load_s) begin
        out_addr_r   <= print_stat_epa_p;
        out_data_r   <= fifo_data_s;
        out_mask_r   <= {mask_width_lp{1'b1}};
        out_src_x_r  <= my_x_i;
        out_src_y_r  <= my_y_i;
        out_dest_x_r <= dest_x_i;
        out_dest_y_r <= dest_y_i;
      end
      case (state_r)
        eIdle: begin
          if (fence_i) begin
            state_r <= eFenced;
          end else if (load_s) begin
            state_r <= eSend;
            out_v_r <= 1'b1;
          end
        end
        eSend: begin
          if (hs_s & ~load_s) begin
            state_r <= eIdle;
            out_v_r <= 1'b0;
          end
        end
        eFenced: begin
          if (~fence_i) state_r <= eIdle;
        end
        default: begin
          state_r <= eIdle;
          out_v_r <= 1'b0;
        end
      endcase
    end
  end

  assign tag_ready_o  = fifo_ready_s;
  assign out_v_o      = out_v_r;
  assign out_addr_o   = out_addr_r;
  assign out_data_o   = out_data_r;
  assign out_mask_o   = out_mask_r;
  assign out_src_x_o  = out_src_x_r;
  assign out_src_y_o  = out_src_y_r;
  assign out_dest_x_o = out_dest_x_r;
  assign out_dest_y_o = out_dest_y_r;
  assign credits_o    = credits_r;
  assign fence_done_o = fence_done_r;
  assign error_o      = error_r;

endmodule

// File: tb/tb_bsg_print_stat_issuer.sv
// Directed bench for bsg_print_stat_issuer: vector table plus hand sequences.
module tb_bsg_print_stat_issuer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_i = 1'b1;
  logic        tag_v = 1'b0, fence = 1'b0, out_ready = 1'b0, credit_v = 1'b0;
  logic [31:0] tag = 32'h0;
  logic        tag_ready, out_v, fence_done, error;
  logic [27:0] out_addr;
  logic [31:0] out_data;
  logic [3:0]  out_mask, credits;
  logic [6:0]  src_x, src_y, dst_x, dst_y;
  logic [6:0]  my_x = 7'd3, my_y = 7'd5, dest_x = 7'd0, dest_y = 7'd1;

  logic        b_tag_v = 1'b0, b_out_ready = 1'b1, b_credit_v = 1'b0;
  logic [31:0] b_tag = 32'h0;
  logic        b_tag_ready, b_out_v, b_fence_done, b_error;
  logic [27:0] b_out_addr;
  logic [31:0] b_out_data;
  logic [3:0]  b_out_mask;
  logic [1:0]  b_credits;
  logic [6:0]  b_src_x, b_src_y, b_dst_x, b_dst_y;

  bsg_print_stat_issuer dut (
    .clk_i(clk), .reset_i(reset_i), .tag_v_i(tag_v), .tag_i(tag), .tag_ready_o(tag_ready),
    .my_x_i(my_x), .my_y_i(my_y), .dest_x_i(dest_x), .dest_y_i(dest_y), .fence_i(fence),
    .out_v_o(out_v), .out_addr_o(out_addr), .out_data_o(out_data), .out_mask_o(out_mask),
    .out_src_x_o(src_x), .out_src_y_o(src_y), .out_dest_x_o(dst_x), .out_dest_y_o(dst_y),
    .out_ready_i(out_ready), .credit_v_i(credit_v), .credits_o(credits),
    .fence_done_o(fence_done), .error_o(error)
  );

  bsg_print_stat_issuer #(.max_out_credits_p(2)) dut2 (
    .clk_i(clk), .reset_i(reset_i), .tag_v_i(b_tag_v), .tag_i(b_tag), .tag_ready_o(b_tag_ready),
    .my_x_i(my_x), .my_y_i(my_y), .dest_x_i(dest_x), .dest_y_i(dest_y), .fence_i(1'b0),
    .out_v_o(b_out_v), .out_addr_o(b_out_addr), .out_data_o(b_out_data), .out_mask_o(b_out_mask),
    .out_src_x_o(b_src_x), .out_src_y_o(b_src_y), .out_dest_x_o(b_dst_x), .out_dest_y_o(b_dst_y),
    .out_ready_i(b_out_ready), .credit_v_i(b_credit_v), .credits_o(b_credits),
    .fence_done_o(b_fence_done), .error_o(b_error)
  );

  int checks = 0;
  int errors = 0;
  int a_pkts = 0;
  int b_pkts = 0;

  always @(posedge clk) begin
    if (out_v && out_ready) a_pkts <= a_pkts + 1;
    if (b_out_v && b_out_ready) b_pkts <= b_pkts + 1;
  end

  typedef struct {
    logic        rst;
    logic        tv;
    logic [31:0] tg;
    logic        ordy;
    logic        cv;
    logic        ev;
    logic [31:0] edata;
    logic [3:0]  ecr;
    logic        erdy;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic tv, input logic [31:0] tg,
                              input logic ordy, input logic cv, input logic ev,
                              input logic [31:0] edata, input logic [3:0] ecr, input logic erdy);
    vec_t v;
    v.rst = rst; v.tv = tv; v.tg = tg; v.ordy = ordy; v.cv = cv;
    v.ev = ev; v.edata = edata; v.ecr = ecr; v.erdy = erdy;
    return v;
  endfunction

  initial begin
    int n0;
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    // single tag, then reset, then fill/hold/release, then coincident credit
    vecs.push_back(mk(1'b0, 1'b1, 32'hDEAD_0001, 1'b1, 1'b0, 1'b0, 32'h0,         4'd8, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 32'hDEAD_0001, 4'd8, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0,         4'd7, 1'b1));
    vecs.push_back(mk(1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         4'd8, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 32'hB000_0001, 1'b0, 1'b0, 1'b0, 32'h0,         4'd8, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 32'hB000_0002, 1'b0, 1'b0, 1'b1, 32'hB000_0001, 4'd8, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 32'hB000_0003, 1'b0, 1'b0, 1'b1, 32'hB000_0001, 4'd8, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 32'hB000_0004, 1'b0, 1'b0, 1'b1, 32'hB000_0001, 4'd8, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 32'hB000_0005, 1'b0, 1'b0, 1'b1, 32'hB000_0001, 4'd8, 1'b0));
    for (int i = 0; i < 10; i++)
      vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hB000_0001, 4'd8, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 32'hB000_0002, 4'd7, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 32'hB000_0003, 4'd6, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 32'hB000_0004, 4'd5, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 32'hB000_0005, 4'd4, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0,         4'd3, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 32'hC000_0001, 1'b1, 1'b0, 1'b0, 32'h0,         4'd3, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 32'hC000_0001, 4'd3, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 32'h0,         4'd3, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0,         4'd3, 1'b1));

    tick(); tick();
    reset_i = 1'b0;
    tick();
    check("rst_out_v", out_v, 0);
    check("rst_credits", credits, 8);
    check("rst_tag_ready", tag_ready, 1);
    check("rst_fence_done", fence_done, 0);
    check("rst_error", error, 0);
    check("rst_addr", out_addr, 0);
    check("rst_data", out_data, 0);
    check("rst_mask", out_mask, 0);

    foreach (vecs[i]) begin
      reset_i = vecs[i].rst; tag_v = vecs[i].tv; tag = vecs[i].tg;
      out_ready = vecs[i].ordy; credit_v = vecs[i].cv;
      tick();
      check($sformatf("vec%0d_out_v", i), out_v, vecs[i].ev);
      check($sformatf("vec%0d_credits", i), credits, vecs[i].ecr);
      check($sformatf("vec%0d_tag_ready", i), tag_ready, vecs[i].erdy);
      if (vecs[i].ev) begin
        check($sformatf("vec%0d_data", i), out_data, vecs[i].edata);
        check($sformatf("vec%0d_addr", i), out_addr, 32'h0000_0D0C);
        check($sformatf("vec%0d_mask", i), out_mask, 4'hF);
        check($sformatf("vec%0d_src", i), {src_x, src_y}, {7'd3, 7'd5});
        check($sformatf("vec%0d_dest", i), {dst_x, dst_y}, {7'd0, 7'd1});
      end
    end
    reset_i = 1'b0; tag_v = 1'b0; credit_v = 1'b0;

    // two-credit instance: third tag waits for a returned credit
    b_out_ready = 1'b1;
    b_tag_v = 1'b1; b_tag = 32'hD000_0001; tick();
    b_tag = 32'hD000_0002; tick();
    b_tag = 32'hD000_0003; tick();
    b_tag_v = 1'b0;
    repeat (6) tick();
    check("c2_pkts_held", b_pkts, 2);
    check("c2_credits_zero", b_credits, 0);
    check("c2_out_v_held", b_out_v, 0);
    b_credit_v = 1'b1; tick(); b_credit_v = 1'b0;
    check("c2_credit_back", b_credits, 1);
    check("c2_not_yet", b_out_v, 0);
    tick();
    check("c2_third_v", b_out_v, 1);
    check("c2_third_data", b_out_data, 32'hD000_0003);
    tick();
    check("c2_credits_after", b_credits, 0);
    check("c2_pkts_total", b_pkts, 3);

    // fence with outstanding credits and a buffered tag
    reset_i = 1'b1; tick(); reset_i = 1'b0;
    out_ready = 1'b1;
    tag_v = 1'b1; tag = 32'hE000_0001; tick();
    tag = 32'hE000_0002; tick();
    tag_v = 1'b0; tick(); tick();
    check("f_credits_out", credits, 6);
    fence = 1'b1; tick();
    tag_v = 1'b1; tag = 32'hE000_0003; tick(); tag_v = 1'b0;
    n0 = a_pkts;
    repeat (4) tick();
    check("f_no_issue_pkts", a_pkts - n0, 0);
    check("f_no_issue_v", out_v, 0);
    credit_v = 1'b1; tick(); tick(); credit_v = 1'b0;
    repeat (3) tick();
    check("f_credits_home", credits, 8);
    check("f_done_buffered", fence_done, 0);
    fence = 1'b0;
    for (int i = 0; i < 6 && !out_v; i++) tick();
    check("f_release_v", out_v, 1);
    check("f_release_data", out_data, 32'hE000_0003);
    tick();
    check("f_release_credits", credits, 7);
    fence = 1'b1; tick(); tick();
    credit_v = 1'b1; tick(); credit_v = 1'b0;
    repeat (3) tick();
    check("f_done", fence_done, 1);
    check("f_done_credits", credits, 8);

    // credit overflow, then reset during a held packet
    fence = 1'b0; tick();
    credit_v = 1'b1; tick(); credit_v = 1'b0;
    check("ov_error", error, 1);
    check("ov_credits", credits, 8);
    tick();
    check("ov_sticky", error, 1);
    tag_v = 1'b1; tag = 32'hF000_0001; tick(); tag_v = 1'b0; tick(); tick();
    check("mr_credits_pre", credits, 7);
    out_ready = 1'b0;
    tag_v = 1'b1; tag = 32'hF000_0002; tick();
    tag = 32'hF000_0003; tick(); tag_v = 1'b0;
    check("mr_held_v", out_v, 1);
    check("mr_held_data", out_data, 32'hF000_0002);
    reset_i = 1'b1; tick(); reset_i = 1'b0;
    check("mr_out_v", out_v, 0);
    check("mr_error", error, 0);
    check("mr_credits", credits, 8);
    check("mr_tag_ready", tag_ready, 1);
    repeat (3) tick();
    check("mr_flushed", out_v, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
